// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access: memory-stage data-access unit.
// Turns a valid load/store from the execute stage into a single
// request/grant/response transaction on the data bus, formats load data
// into M_valM_o and raises memory_ready_o when the result can be latched.
//
// Optional build macro: MEM_BUS_TIMEOUT_EN
//   Defined   : a bus-wait counter aborts a stuck transaction after
//               TIMEOUT_CYC cycles in REQ/WAIT and flags M_bus_err_o.
//   Undefined : no counter, the FSM waits indefinitely, M_bus_err_o = 0.
// ---------------------------------------------------------------------------
module memory_access #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            execute_vaild_i,
  input  logic            ED_mem_read_i,
  input  logic            ED_mem_write_i,
  input  logic [2:0]      ED_funct3_i,
  input  logic [XLEN-1:0] ED_valE_i,
  input  logic [XLEN-1:0] ED_valB_i,
  input  logic            write_back_allow_in_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [3:0]      dbus_wstrb_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  output logic [XLEN-1:0] M_valM_o,
  output logic            memory_ready_o,
  output logic            M_bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Transaction registers: captured in IDLE, held stable until the next op.
  logic [XLEN-1:0] addr_q,  addr_d;
  logic            we_q,    we_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [2:0]      f3_q,    f3_d;
  logic [1:0]      off_q,   off_d;
  logic [XLEN-1:0] valm_q,  valm_d;
  logic            err_q,   err_d;

  logic            mem_op;
  logic            timeout_hit;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [1:0]      ed_off;

  assign mem_op = execute_vaild_i & (ED_mem_read_i | ED_mem_write_i);
  assign ed_off = ED_valE_i[1:0];

`ifdef MEM_BUS_TIMEOUT_EN
  // Counter is at least 8 bits wide, wider if the limit needs it.
  localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter reaches the limit on the edge that leaves REQ/WAIT for DONE.
  assign timeout_hit = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Bus-wait counter: cleared on entry to REQ, counts while in REQ/WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_IDLE) && mem_op) begin
      cnt_d = '0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Bus-wait counter register.
  always_ff @(posedge clk_i) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // Without the timeout the limit never fires; a negative limit is meaningless.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  // Store lane steering from the incoming funct3 and address offset.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = ED_valB_i;
    case (ED_funct3_i)
      3'b000: begin
        st_wstrb = 4'b0001 << ed_off;
        st_wdata = {4{ED_valB_i[7:0]}};
      end
      3'b001: begin
        st_wstrb = 4'b0011 << {ed_off[1], 1'b0};
        st_wdata = {2{ED_valB_i[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = ED_valB_i;
      end
    endcase
  end

  // Load formatting from the response data and the captured offset/funct3.
  always_comb begin
    ld_byte = dbus_rdata_i[8*off_q +: 8];
    ld_half = off_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (f3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dbus_rdata_i;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; a grant or response beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mem_op) state_d = S_REQ;
      S_REQ: begin
        if (dbus_gnt_i)       state_d = S_WAIT;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_WAIT: if (dbus_rvalid_i || timeout_hit) state_d = S_DONE;
      S_DONE: if (write_back_allow_in_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request is live only in REQ; ready when done or nothing to do.
  always_comb begin
    dbus_req_o     = (state_q == S_REQ);
    memory_ready_o = (state_q == S_DONE) || ((state_q == S_IDLE) && !mem_op);
  end

  // Datapath next values: capture on issue, load result on response.
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    off_d   = off_q;
    valm_d  = valm_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          addr_d = {ED_valE_i[XLEN-1:2], 2'b00};
          we_d   = ED_mem_write_i;
          f3_d   = ED_funct3_i;
          off_d  = ed_off;
          if (ED_mem_write_i) begin
            wstrb_d = st_wstrb;
            wdata_d = st_wdata;
          end else begin
            wstrb_d = 4'b0000;
            wdata_d = '0;
          end
        end
      end
      S_REQ: begin
        if (!dbus_gnt_i && timeout_hit) begin
          valm_d = '0;
          err_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (dbus_rvalid_i) begin
          valm_d = we_q ? '0 : ld_data;
        end else if (timeout_hit) begin
          valm_d = '0;
          err_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (write_back_allow_in_i) err_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      valm_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
    end
  end

  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = wdata_q;
  assign dbus_wstrb_o = wstrb_q;
  assign M_valM_o     = valm_q;
  assign M_bus_err_o  = err_q;

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory-stage data-access unit. Sits between execute-stage outputs (ED_*) and memory_reg.
- Turns a valid load/store into a request/grant/response transaction on the data bus.
- Formats load data into M_valM_o and raises memory_ready_o when the stage result may be latched.
- memory_reg advances only on memory_ready_o & write_back_allow_in_i; this block uses the same condition to release its result.

Parameters:
XLEN, 32, data/address width (fixed 32; byte lanes assume 4 bytes)
TIMEOUT_CYC, 255, bus-wait cycle limit; used only with MEM_BUS_TIMEOUT_EN

Ports:
clk_i  in  1  clock
rst  in  1  synchronous active-high reset
execute_vaild_i  in  1  ED_* inputs carry a valid instruction
ED_mem_read_i  in  1  instruction is a load
ED_mem_write_i  in  1  instruction is a store
ED_funct3_i  in  3  access size/sign (RV32I load/store funct3)
ED_valE_i  in  XLEN  effective address
ED_valB_i  in  XLEN  store data
write_back_allow_in_i  in  1  downstream accepts this cycle
dbus_req_o  out  1  bus request
dbus_we_o  out  1  1 = write
dbus_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dbus_wdata_o  out  XLEN  lane-replicated store data
dbus_wstrb_o  out  4  byte enables
dbus_gnt_i  in  1  request accepted
dbus_rvalid_i  in  1  response/ack valid
dbus_rdata_i  in  XLEN  read data
M_valM_o  out  XLEN  formatted load result (0 for stores)
memory_ready_o  out  1  stage result complete
M_bus_err_o  out  1  bus timeout flag (feature only)

Behaviour:
- FSM states are IDLE, REQ, WAIT and DONE. Reset and post-reset state is IDLE.
- Reset values: dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_wdata_o=0, dbus_wstrb_o=0, M_valM_o=0, M_bus_err_o=0.
- Memory op is defined as execute_vaild_i & (ED_mem_read_i | ED_mem_write_i). If read and write are both set, the op is treated as a store.
- memory_ready_o is combinational: 1 when in DONE, or when in IDLE with no memory op; otherwise 0.
- IDLE, memory op present: register addr/we/wdata/wstrb, set dbus_req_o=1, go to REQ.
- REQ: hold dbus_req_o and all bus fields stable until dbus_gnt_i. On gnt, dbus_req_o=0 and go to WAIT.
- WAIT: on dbus_rvalid_i go to DONE.
  - Load: M_valM_o is formatted from dbus_rdata_i.
  - Store: M_valM_o=0.
  - rvalid is ignored in every other state.
- DONE: hold M_valM_o. If write_back_allow_in_i, go to IDLE; the next instruction is seen the following cycle, so there is no double issue.
- Minimum latency from op arrival to memory_ready_o=1 is 3 cycles (gnt in the first REQ cycle, rvalid in the first WAIT cycle).
- Byte lanes, with o = addr[1:0]:
  - SB: wstrb = 4'b0001<<o, wdata = {4{b}}.
  - SH: wstrb = 4'b0011<<{o[1],1'b0}, wdata = {2{h}}.
  - SW: wstrb = 4'b1111.
  - Loads: wstrb = 0.
- Load format:
  - LB/LBU: select byte o, then sign- or zero-extend.
  - LH/LHU: select half o[1], then sign- or zero-extend.
  - LW: full word.
  - Undefined funct3 is treated as LW/SW.
- Misaligned addresses are not trapped; the low bits only select lanes.
- Reset mid-operation: state returns to IDLE immediately and dbus_req_o drops. A late rvalid arriving in IDLE is discarded.
- execute_vaild_i dropping while in REQ/WAIT does not abort the transaction. The transaction completes to DONE; the stale result is discarded downstream by memory_reg.

Optional Feature:
MEM_BUS_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When the counter reaches TIMEOUT_CYC, dbus_req_o=0, M_valM_o=0, M_bus_err_o=1 and the FSM goes to DONE.
  - M_bus_err_o clears when leaving DONE.
- Not defined: no counter; the FSM waits indefinitely and M_bus_err_o is tied 0.

Test Plan:
1. LW addr 0x100; gnt in the first REQ cycle, rvalid 1 cycle later with 0xDEADBEEF; write_back_allow_in_i=1 -> memory_ready_o high at cycle 3, M_valM_o=0xDEADBEEF, back to IDLE next cycle.
2. LB addr 0x103, rdata 0x80FFFFFF -> M_valM_o=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102, rdata 0xBEEF1234 -> 0x0000BEEF.
3. SH addr 0x206, data 0x0000ABCD -> dbus_wstrb_o=4'b1100, dbus_wdata_o=0xABCDABCD, dbus_addr_o=0x204, dbus_we_o=1. After the rvalid ack, M_valM_o=0.
4. gnt delayed 4 cycles and write_back_allow_in_i low 3 cycles in DONE -> bus fields stable throughout REQ; memory_ready_o held 1 and M_valM_o stable until allow_in, then IDLE.
5. rst asserted in WAIT, rvalid arrives the cycle after reset -> all outputs at reset values, state IDLE, no DONE, memory_ready_o=1 with no op present.
6. (MEM_BUS_TIMEOUT_EN, TIMEOUT_CYC=8) gnt never asserted -> 8 cycles after entering REQ: req drops, M_bus_err_o=1, memory_ready_o=1, M_valM_o=0.
